byte_xfer_sequencer: RTL and testbench
======================================

Name: byte_xfer_sequencer

Overview:
- Parametrised multi-byte memory transfer sequencer for the CPU datapath.
- Moves an N-byte word between a register-width buffer and the byte-wide memory, one byte per cycle.
- Replaces the fixed hard-coded byte-store sequence in the control unit. Supports read and write, optional 8-bit offset addressing, selectable endianness, memory wait-states and abort.
- Sits between the control unit (start/done handshake) and the memory (CS/WR/address/data).

Parameters:
- ADDR_W, 16: width of memory address, base address and end address.
- DATA_BYTES, 4: maximum bytes per transfer; data buses are 8*DATA_BYTES wide.
- CNT_W, 3: width of nbytes; must satisfy 2^CNT_W > DATA_BYTES.

Ports:
- Clock  in  1  system clock, rising edge
- Reset  in  1  asynchronous, active-high reset
- start  in  1  request a transfer; sampled only in IDLE
- rw  in  1  0 = read memory into rdata, 1 = write wdata to memory
- big_endian  in  1  lane ordering mode; sampled with start
- use_offset  in  1  1 = effective address is base_addr + offset
- base_addr  in  ADDR_W  transfer base address
- offset  in  8  unsigned offset, zero-extended
- nbytes  in  CNT_W  byte count 1..DATA_BYTES; 0 or values above DATA_BYTES mean DATA_BYTES
- wdata  in  8*DATA_BYTES  write data; captured at start
- abort  in  1  cancel an in-progress transfer
- mem_rdata  in  8  memory read byte
- mem_ready  in  1  memory completes the current byte this cycle
- mem_addr  out  ADDR_W  current byte address
- mem_wdata  out  8  byte being written
- mem_cs_n  out  1  memory chip select, active-low
- mem_wr  out  1  1 = write cycle
- rdata  out  8*DATA_BYTES  assembled read word
- end_addr  out  ADDR_W  address following the last transferred byte
- busy  out  1  high in EA and XFER states
- done  out  1  one-cycle pulse on normal completion
- aborted  out  1  one-cycle pulse after an abort

Behaviour:
- Reset (asynchronous)
  - State goes to IDLE.
  - Outputs reset to: mem_cs_n=1, mem_wr=0, busy=0, done=0, aborted=0.
  - rdata, end_addr, mem_addr and mem_wdata reset to 0.
- States: IDLE, EA, XFER, DONE, ABORT. All state registers are updated on the rising edge of Clock.
- IDLE
  - Outputs: mem_cs_n=1, busy=0.
  - If start=1, the block latches rw, big_endian, wdata and the effective nbytes (n), clears the byte counter k to 0, and goes to EA.
  - For reads, rdata is cleared to 0 at this edge.
- EA (one cycle)
  - cur_addr <= use_offset ? base_addr + {0, offset} : base_addr.
  - The sum is taken modulo 2^ADDR_W (wraps).
  - mem_cs_n stays 1. Next state is XFER.
- XFER
  - Outputs: mem_cs_n=0, mem_wr=rw, mem_addr=cur_addr.
  - Lane select: L = big_endian ? n-1-k : k.
  - mem_wdata = wdata_latched[8L+7:8L]; it is 0 when rw=0.
  - On an edge with mem_ready=1:
    - For reads, rdata[8L+7:8L] <= mem_rdata.
    - cur_addr increments, wrapping modulo 2^ADDR_W.
    - k increments.
    - If k was n-1, the next state is DONE.
  - On an edge with mem_ready=0: hold; address, data and counter are unchanged.
- DONE (one cycle)
  - Outputs: done=1, busy=0, mem_cs_n=1.
  - end_addr <= cur_addr, i.e. EA + n modulo 2^ADDR_W.
  - Next state is IDLE; start is not accepted in DONE.
- ABORT
  - abort=1 at an edge in EA or XFER takes precedence over mem_ready and moves the block to ABORT.
  - Neither the pending byte nor its rdata lane is committed.
  - ABORT lasts one cycle: aborted=1, busy=0, mem_cs_n=1. rdata keeps any lanes already captured; end_addr is unchanged.
  - Next state is IDLE.
  - abort has no effect in IDLE, DONE or ABORT.
- start while busy, in DONE or in ABORT is ignored (not queued).
- Latency with mem_ready tied high:
  - start is sampled at edge E0.
  - EA occupies cycle 1 and XFER occupies cycles 2..n+1.
  - done is high in cycle n+2.
- rdata and end_addr hold their values until the next accepted start or Reset.
- Reset asserted mid-transfer returns the block to IDLE immediately. No done or aborted pulse is produced, and mem_cs_n goes to 1 asynchronously.

Test Plan:
- Write, little-endian, defaults: base_addr=0x0040, use_offset=1, offset=0x10, nbytes=4, wdata=0xDDCCBBAA, mem_ready=1 -> writes at 0x0050..0x0053 of AA,BB,CC,DD. done pulses in cycle 6 after start; end_addr=0x0054.
- Read, big-endian, nbytes=2: memory 0x0100=0x12, 0x0101=0x34 -> rdata=0x00001234, end_addr=0x0102.
- Wait-states: same as the first scenario with mem_ready low for 2 cycles on byte 1 -> mem_addr holds at 0x0051 for 3 cycles, mem_wdata holds at BB, and done is delayed by 2 cycles.
- Wrap-around: base_addr=0xFFFE, offset=0x01, nbytes=4 -> addresses FFFF, 0000, 0001, 0002; end_addr=0x0003.
- Abort: read with nbytes=4 and abort asserted on the edge where byte 2 would complete -> lanes 0-1 captured, lanes 2-3 stay 0, aborted pulses once, done never asserts, end_addr unchanged.
- Reset and ignored start: start pulsed while busy is ignored. Asserting Reset during XFER gives mem_cs_n=1, busy=0 and rdata=0 immediately, with no done pulse. nbytes=0 transfers 4 bytes.

Source files
------------

// File: rtl/byte_xfer_sequencer.sv
// byte_xfer_sequencer
// Moves an N-byte word between a register-width buffer and byte-wide memory,
// one byte per cycle. Supports read/write, optional 8-bit offset addressing,
// selectable endianness, memory wait-states and abort.
module byte_xfer_sequencer #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_BYTES = 4,
    parameter int unsigned CNT_W      = 3
) (
    input  logic                    Clock,
    input  logic                    Reset,
    input  logic                    start,
    input  logic                    rw,
    input  logic                    big_endian,
    input  logic                    use_offset,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [7:0]              offset,
    input  logic [CNT_W-1:0]        nbytes,
    input  logic [8*DATA_BYTES-1:0] wdata,
    input  logic                    abort,
    input  logic [7:0]              mem_rdata,
    input  logic                    mem_ready,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [7:0]              mem_wdata,
    output logic                    mem_cs_n,
    output logic                    mem_wr,
    output logic [8*DATA_BYTES-1:0] rdata,
    output logic [ADDR_W-1:0]       end_addr,
    output logic                    busy,
    output logic                    done,
    output logic                    aborted
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_EA    = 3'd1;
    localparam logic [2:0] S_XFER  = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ABORT = 3'd4;

    logic [2:0]              state;
    logic                    rw_q;
    logic                    be_q;
    logic [8*DATA_BYTES-1:0] wdata_q;
    logic [CNT_W-1:0]        n_q;
    logic [CNT_W-1:0]        k_q;
    logic [ADDR_W-1:0]       cur_addr;
    logic [8*DATA_BYTES-1:0] rdata_q;
    logic [ADDR_W-1:0]       end_addr_q;

    logic [CNT_W-1:0]        n_eff;
    logic [CNT_W-1:0]        lane;
    logic                    last_byte;
    logic [7:0]              lane_byte;

    // Effective byte count, lane selection and last-byte detection
    always_comb begin
        if (nbytes == '0 || nbytes > CNT_W'(DATA_BYTES))
            n_eff = CNT_W'(DATA_BYTES);
        else
            n_eff = nbytes;
        lane      = be_q ? (n_q - CNT_W'(1) - k_q) : k_q;
        last_byte = (k_q == n_q - CNT_W'(1));
    end

    // Select the write byte for the current lane from the latched word
    always_comb begin
        lane_byte = '0;
        for (int unsigned i = 0; i < DATA_BYTES; i++) begin
            if (lane == CNT_W'(i))
                lane_byte = wdata_q[8*i +: 8];
        end
    end

    // Sequencer state, address counter, byte counter and captured data
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= S_IDLE;
            rw_q       <= 1'b0;
            be_q       <= 1'b0;
            wdata_q    <= '0;
            n_q        <= '0;
            k_q        <= '0;
            cur_addr   <= '0;
            rdata_q    <= '0;
            end_addr_q <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        rw_q    <= rw;
                        be_q    <= big_endian;
                        wdata_q <= wdata;
                        n_q     <= n_eff;
                        k_q     <= '0;
                        if (!rw)
                            rdata_q <= '0;
                        state   <= S_EA;
                    end
                end
                S_EA: begin
                    if (abort) begin
                        state <= S_ABORT;
                    end else begin
                        cur_addr <= use_offset ? base_addr + ADDR_W'(offset) : base_addr;
                        state    <= S_XFER;
                    end
                end
                S_XFER: begin
                    // Abort wins over mem_ready so the pending byte is never committed
                    if (abort) begin
                        state <= S_ABORT;
                    end else if (mem_ready) begin
                        if (!rw_q) begin
                            for (int unsigned i = 0; i < DATA_BYTES; i++) begin
                                if (lane == CNT_W'(i))
                                    rdata_q[8*i +: 8] <= mem_rdata;
                            end
                        end
                        cur_addr <= cur_addr + ADDR_W'(1);
                        k_q      <= k_q + CNT_W'(1);
                        if (last_byte)
                            state <= S_DONE;
                    end
                end
                S_DONE: begin
                    end_addr_q <= cur_addr;
                    state      <= S_IDLE;
                end
                S_ABORT: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory-side and handshake outputs decoded from state
    always_comb begin
        mem_cs_n  = (state != S_XFER);
        mem_wr    = (state == S_XFER) && rw_q;
        mem_addr  = (state == S_XFER) ? cur_addr : '0;
        mem_wdata = ((state == S_XFER) && rw_q) ? lane_byte : '0;
        busy      = (state == S_EA) || (state == S_XFER);
        done      = (state == S_DONE);
        aborted   = (state == S_ABORT);
        rdata     = rdata_q;
        end_addr  = end_addr_q;
    end

endmodule

// File: tb/tb_byte_xfer_sequencer.sv
// tb_byte_xfer_sequencer
// Directed scenarios for byte_xfer_sequencer with a transaction scoreboard.
module tb_byte_xfer_sequencer;

    logic        Clock;
    logic        Reset;
    logic        start;
    logic        rw;
    logic        big_endian;
    logic        use_offset;
    logic [15:0] base_addr;
    logic [7:0]  offset;
    logic [2:0]  nbytes;
    logic [31:0] wdata;
    logic        abort;
    logic [7:0]  mem_rdata;
    logic        mem_ready;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_cs_n;
    logic        mem_wr;
    logic [31:0] rdata;
    logic [15:0] end_addr;
    logic        busy;
    logic        done;
    logic        aborted;

    byte_xfer_sequencer #(
        .ADDR_W     (16),
        .DATA_BYTES (4),
        .CNT_W      (3)
    ) dut (
        .Clock      (Clock),
        .Reset      (Reset),
        .start      (start),
        .rw         (rw),
        .big_endian (big_endian),
        .use_offset (use_offset),
        .base_addr  (base_addr),
        .offset     (offset),
        .nbytes     (nbytes),
        .wdata      (wdata),
        .abort      (abort),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_cs_n   (mem_cs_n),
        .mem_wr     (mem_wr),
        .rdata      (rdata),
        .end_addr   (end_addr),
        .busy       (busy),
        .done       (done),
        .aborted    (aborted)
    );

    typedef struct packed {
        logic [15:0] a;
        logic        w;
        logic [7:0]  d;
    } txn_t;

    txn_t exp_q[$];
    txn_t obs_q[$];
    int   tests = 0;
    int   fails = 0;
    int   done_cnt = 0;
    int   ab_cnt = 0;
    logic [15:0] tr_addr [0:40];
    logic [7:0]  tr_wd   [0:40];
    logic        tr_cs   [0:40];

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Memory read model: two fixed bytes, otherwise an address-derived pattern
    function automatic logic [7:0] model_rd(input logic [15:0] a);
        if (a == 16'h0100) return 8'h12;
        if (a == 16'h0101) return 8'h34;
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    assign mem_rdata = model_rd(mem_addr);

    // Record completed memory byte cycles and handshake pulses
    always @(negedge Clock) begin
        if (!mem_cs_n && mem_ready && !abort)
            obs_q.push_back('{a: mem_addr, w: mem_wr, d: mem_wdata});
        if (done)
            done_cnt++;
        if (aborted)
            ab_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Push the byte cycles the model expects to complete; returns expected rdata
    task automatic push_expect(input logic r, input logic b, input logic [15:0] ea,
                               input int n, input int n_commit, input logic [31:0] wd,
                               output logic [31:0] exp_rd);
        int   ln;
        txn_t t;
        exp_rd = '0;
        for (int k = 0; k < n_commit; k++) begin
            ln  = b ? (n - 1 - k) : k;
            t.a = ea + 16'(k);
            t.w = r;
            t.d = r ? wd[8*ln +: 8] : 8'h00;
            if (!r)
                exp_rd[8*ln +: 8] = model_rd(t.a);
            exp_q.push_back(t);
        end
    endtask

    // Compare observed byte cycles against expectations, then clear both queues
    task automatic score(input string tag);
        txn_t e;
        txn_t o;
        check({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            check({tag, "_txn"}, 64'(o), 64'(e));
        end
        exp_q.delete();
        obs_q.delete();
    endtask

    // Run one transfer; cycle c counts from the edge that samples start
    task automatic run_xfer(input logic r, input logic b, input logic u,
                            input logic [15:0] base, input logic [7:0] off,
                            input logic [2:0] nb, input logic [31:0] wd,
                            input int lo, input int len, input int abort_at,
                            input int poke_at, input int reset_at,
                            output int done_c, output int ab_c);
        bit rst_seen;
        done_c   = -1;
        ab_c     = -1;
        rst_seen = 0;
        @(posedge Clock); #1;
        rw = r; big_endian = b; use_offset = u; base_addr = base; offset = off;
        nbytes = nb; wdata = wd; mem_ready = 1'b1; abort = 1'b0; start = 1'b1;
        @(posedge Clock); #1;
        start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            mem_ready = !(c >= lo && c < lo + len);
            abort     = (c == abort_at);
            start     = (c == poke_at);
            if (c == reset_at) begin
                Reset = 1'b1;
                #1;
                check("rst_cs_n", 64'(mem_cs_n), 64'd1);
                check("rst_busy", 64'(busy), 64'd0);
                check("rst_rdata", 64'(rdata), 64'd0);
                check("rst_done", 64'(done), 64'd0);
                Reset = 1'b0;
                start = 1'b0;
                rst_seen = 1;
                break;
            end
            @(negedge Clock);
            tr_addr[c] = mem_addr;
            tr_wd[c]   = mem_wdata;
            tr_cs[c]   = mem_cs_n;
            if (done && done_c < 0)   done_c = c;
            if (aborted && ab_c < 0)  ab_c = c;
            if (done_c > 0 || ab_c > 0) break;
            @(posedge Clock); #1;
        end
        start = 1'b0;
        abort = 1'b0;
        mem_ready = 1'b1;
        check("completion_in_budget", 64'(done_c > 0 || ab_c > 0 || rst_seen), 64'd1);
    endtask

    initial begin
        int          dc;
        int          ac;
        int          d0;
        int          a0;
        logic [31:0] er;

        Reset = 1'b1; start = 1'b0; rw = 1'b0; big_endian = 1'b0; use_offset = 1'b0;
        base_addr = '0; offset = '0; nbytes = '0; wdata = '0; abort = 1'b0; mem_ready = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        check("reset_cs_n", 64'(mem_cs_n), 64'd1);
        check("reset_wr", 64'(mem_wr), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_aborted", 64'(aborted), 64'd0);
        check("reset_rdata", 64'(rdata), 64'd0);
        check("reset_end_addr", 64'(end_addr), 64'd0);
        check("reset_mem_addr", 64'(mem_addr), 64'd0);
        Reset = 1'b0;

        // Write, little-endian, offset addressing
        push_expect(1'b1, 1'b0, 16'h0050, 4, 4, 32'hDDCCBBAA, er);
        run_xfer(1'b1, 1'b0, 1'b1, 16'h0040, 8'h10, 3'd4, 32'hDDCCBBAA, 0, 0, 0, 0, 0, dc, ac);
        check("wr_le_done_cycle", 64'(dc), 64'd6);
        check("wr_le_ea_cs_n", 64'(tr_cs[1]), 64'd1);
        @(posedge Clock); #1;
        check("wr_le_end_addr", 64'(end_addr), 64'h0054);
        score("wr_le");

        // Read, big-endian, two bytes
        push_expect(1'b0, 1'b1, 16'h0100, 2, 2, 32'h0, er);
        run_xfer(1'b0, 1'b1, 1'b0, 16'h0100, 8'h00, 3'd2, 32'hFFFFFFFF, 0, 0, 0, 0, 0, dc, ac);
        check("rd_be_done_cycle", 64'(dc), 64'd4);
        @(posedge Clock); #1;
        check("rd_be_rdata_model", 64'(rdata), 64'(er));
        check("rd_be_rdata", 64'(rdata), 64'h00001234);
        check("rd_be_end_addr", 64'(end_addr), 64'h0102);
        score("rd_be");

        // Wait-states: byte 1 stalls for two cycles
        push_expect(1'b1, 1'b0, 16'h0050, 4, 4, 32'hDDCCBBAA, er);
        run_xfer(1'b1, 1'b0, 1'b1, 16'h0040, 8'h10, 3'd4, 32'hDDCCBBAA, 3, 2, 0, 0, 0, dc, ac);
        check("wait_done_cycle", 64'(dc), 64'd8);
        for (int c = 3; c <= 5; c++) begin
            check("wait_addr_hold", 64'(tr_addr[c]), 64'h0051);
            check("wait_wdata_hold", 64'(tr_wd[c]), 64'hBB);
        end
        @(posedge Clock); #1;
        check("wait_end_addr", 64'(end_addr), 64'h0054);
        score("wait");

        // Address wrap-around
        push_expect(1'b1, 1'b0, 16'hFFFF, 4, 4, 32'h44332211, er);
        run_xfer(1'b1, 1'b0, 1'b1, 16'hFFFE, 8'h01, 3'd4, 32'h44332211, 0, 0, 0, 0, 0, dc, ac);
        check("wrap_done_cycle", 64'(dc), 64'd6);
        @(posedge Clock); #1;
        check("wrap_end_addr", 64'(end_addr), 64'h0003);
        score("wrap");

        // Abort on the edge where byte 2 would complete
        d0 = done_cnt;
        a0 = ab_cnt;
        push_expect(1'b0, 1'b0, 16'h0200, 4, 2, 32'h0, er);
        run_xfer(1'b0, 1'b0, 1'b0, 16'h0200, 8'h00, 3'd4, 32'h0, 0, 0, 4, 0, 0, dc, ac);
        check("abort_cycle", 64'(ac), 64'd5);
        repeat (3) @(posedge Clock);
        #1;
        check("abort_rdata", 64'(rdata), 64'(er));
        check("abort_end_addr", 64'(end_addr), 64'h0003);
        check("abort_pulses", 64'(ab_cnt - a0), 64'd1);
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        score("abort");

        // nbytes=0 means four bytes; start poked mid-transfer must be ignored
        d0 = done_cnt;
        push_expect(1'b1, 1'b0, 16'h0400, 4, 4, 32'h87654321, er);
        run_xfer(1'b1, 1'b0, 1'b0, 16'h0400, 8'h00, 3'd0, 32'h87654321, 0, 0, 0, 3, 0, dc, ac);
        check("n0_done_cycle", 64'(dc), 64'd6);
        repeat (4) @(posedge Clock);
        #1;
        check("n0_end_addr", 64'(end_addr), 64'h0404);
        check("ignored_start_busy", 64'(busy), 64'd0);
        check("ignored_start_done_cnt", 64'(done_cnt - d0), 64'd1);
        score("n0");

        // Reset asserted during XFER
        d0 = done_cnt;
        a0 = ab_cnt;
        push_expect(1'b0, 1'b0, 16'h0300, 4, 2, 32'h0, er);
        run_xfer(1'b0, 1'b0, 1'b0, 16'h0300, 8'h00, 3'd4, 32'h0, 0, 0, 0, 0, 4, dc, ac);
        repeat (4) @(posedge Clock);
        #1;
        check("rst_no_done", 64'(done_cnt - d0), 64'd0);
        check("rst_no_aborted", 64'(ab_cnt - a0), 64'd0);
        check("rst_end_addr", 64'(end_addr), 64'd0);
        check("rst_idle_cs_n", 64'(mem_cs_n), 64'd1);
        score("rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
